serial_adder: RTL and testbench

//  Bit-serial ripple adder: sum = a + b + cin over WIDTH clocks, LSB first,
//  one full-adder cell plus a carry flip-flop. Addition counterpart of the

---
 rtl/serial_arith_pkg.sv | 20 ++
 rtl/full_adder_cell.sv | 27 ++
 rtl/serial_adder.sv | 154 +++++++++++++++
 tb/tb_serial_adder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and sizing helper for the serial arithmetic blocks
//
// Contents:
//   state_e : control FSM states {IDLE, SHIFT, DONE}
//   cnt_w() : bit-counter width able to hold the values 0..width

package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The counter has to reach WIDTH itself, not just WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit full adder built from gate primitives
//
// Ports:
//   a, b : input  addend bits
//   ci   : input  carry in
//   s    : output sum bit
//   co   : output carry out

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  wire p;
  wire g;
  wire t;

  xor u_p  (p, a, b);
  xor u_s  (s, p, ci);
  and u_g  (g, a, b);
  and u_t  (t, p, ci);
  or  u_co (co, g, t);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder (sum = a + b + cin, LSB first)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the signed-overflow output ovf)
//
// Ports:
//   clk   : input  rising-edge clock
//   rst_n : input  asynchronous active-low reset
//   start : input  request, accepted only while not busy
//   a, b  : input  [WIDTH-1:0] operands, captured on an accepted start
//   cin   : input  carry in, captured on an accepted start
//   busy  : output high while bits are being added
//   done  : output one-cycle pulse, sum/cout valid
//   sum   : output [WIDTH-1:0] result, held until the next operation completes
//   cout  : output carry out of the MSB, held with sum
//   ovf   : output signed overflow, held with sum (SERIAL_ADDER_OVF_EN only)

module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               cmsb_q, cmsb_d;
  logic               ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  full_adder_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    cmsb_d   = cmsb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = SHIFT;
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = '0;
          carry_d  = cin;
          cnt_d    = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          // All bits are in; publish the result on the way into DONE.
          state_d = DONE;
          sum_d   = sum_sh_q;
          cout_d  = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = cmsb_q ^ carry_q;
`endif
        end else begin
          sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          carry_d  = fa_co;
          cnt_d    = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDER_OVF_EN
          // Remember the carry entering the MSB for the overflow flag.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cmsb_d = carry_q;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q   <= cmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (directed + random back-to-back)

module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,.ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic; result bits {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
    int u;
    int s;
    logic [WIDTH+1:0] r;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    r[WIDTH-1:0] = u[WIDTH-1:0];
    r[WIDTH]     = (u >= (1 << WIDTH));
    r[WIDTH+1]   = (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
    return r;
  endfunction

  // Clocks until done, counted from the last sampling point; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
    check("done_seen", done, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH+1:0] exp);
    check({tag, "_sum"}, sum, exp[WIDTH-1:0]);
    check({tag, "_cout"}, cout, exp[WIDTH]);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, exp[WIDTH+1]);
`endif
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input logic [WIDTH+1:0] exp);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    @(posedge clk); #1;
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    check({tag, "_busy"}, busy, 1'b1);
    wait_done(lat);
    check({tag, "_lat"}, lat, LAT);
    check_result(tag, exp);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    logic [WIDTH-1:0] ra, rb;
    logic rc;
    logic [WIDTH+1:0] cur_exp, prev_exp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    rst_n = 1'b1;

    // Directed vectors with hand-computed expectations {ovf, cout, sum}.
    run_op("inc", 8'h0F, 8'h01, 1'b0, {1'b0, 1'b0, 8'h10});
    run_op("wrap", 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
    run_op("sovf", 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});

    // Start during SHIFT must be ignored and not queued.
    @(posedge clk); #1;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check_result("ign", {1'b0, 1'b0, 8'h47});
    count_dones(WIDTH + 4, n);
    check("ign_single_done", n, 0);

    // Reset in the middle of an operation aborts it.
    @(posedge clk); #1;
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_sum", sum, '0);
    check("abort_cout", cout, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_dones(WIDTH + 4, n);
    check("abort_no_done", n, 0);
    run_op("post_rst", 8'h05, 8'h03, 1'b0, {1'b0, 1'b0, 8'h08});

    // Random back-to-back: start held high, operands taken at each DONE.
    @(posedge clk); #1;
    ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
    start = 1'b1; a = ra; b = rb; cin = rc;
    cur_exp  = ref_add(ra, rb, rc);
    prev_exp = {1'b0, 1'b0, 8'h08};
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      if (i < 8) check("rnd_hold_sum", sum, prev_exp[WIDTH-1:0]);
      wait_done(lat);
      check("rnd_lat", lat, LAT);
      check_result("rnd", cur_exp);
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      a = ra; b = rb; cin = rc;
      prev_exp = cur_exp;
      cur_exp  = ref_add(ra, rb, rc);
    end
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("end_idle_busy", busy, 1'b0);
    check("end_idle_done", done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
